// File: rtl/codificador.sv
// Registered 4-to-2 request encoder: sticky pending requests are granted one at
// a time over valid/ready, in round-robin (RR=1) or lowest-index-first (RR=0) order.
module codificador #(
    parameter bit RR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       ready,
    output logic       valid,
    output logic [1:0] sel,
    output logic [3:0] pend
);

    // Handshake: a code transfers on every rising edge where valid and ready are
    // both high; once valid rises, sel is held until that transfer edge.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [1:0] ptr, ptr_next, sel_next, sel_inc;
    logic [3:0] pend_next, clr;
    logic       xfer;

    // First set bit of v, scanning upward from p and wrapping past 3.
    function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + i[1:0];
            if (!found && v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign valid   = (state == OFFER);
    assign sel_inc = sel + 2'd1;

    always_comb begin
        xfer       = (state == OFFER) && ready;
        clr        = xfer ? (4'b0001 << sel) : 4'b0000;
        // A bit cleared and re-requested in the same cycle stays pending.
        pend_next  = (pend & ~clr) | (en ? req : 4'b0000);
        state_next = state;
        sel_next   = sel;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (pend_next != 4'b0000) begin
                    state_next = OFFER;
                    sel_next   = pick(pend_next, RR ? ptr : 2'd0);
                end
            end
            OFFER: begin
                if (ready) begin
                    if (RR) ptr_next = sel_inc;
                    if (pend_next != 4'b0000)
                        sel_next = pick(pend_next, RR ? sel_inc : 2'd0);
                    else
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'd0;
            ptr   <= 2'd0;
            pend  <= 4'b0000;
        end else begin
            state <= state_next;
            sel   <= sel_next;
            ptr   <= ptr_next;
            pend  <= pend_next;
        end
    end

endmodule

// File: tb/tb_codificador.sv
// Directed bench for codificador: one round-robin and one fixed-priority instance
// driven by the same stimulus, with hand-computed expected values.
module tb_codificador;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       ready = 1'b0;

    logic       valid, valid_fp;
    logic [1:0] sel, sel_fp;
    logic [3:0] pend, pend_fp;

    int n_checks = 0;
    int n_pass   = 0;

    codificador #(.RR(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .en(en), .req(req), .ready(ready),
        .valid(valid), .sel(sel), .pend(pend)
    );

    codificador #(.RR(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .en(en), .req(req), .ready(ready),
        .valid(valid_fp), .sel(sel_fp), .pend(pend_fp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] r, input logic rdy);
        en    = e;
        req   = r;
        ready = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [1:0] burst_exp [4];

    initial begin
        burst_exp[0] = 2'd0;
        burst_exp[1] = 2'd1;
        burst_exp[2] = 2'd2;
        burst_exp[3] = 2'd3;

        // Reset state
        do_reset();
        #1;
        check("rst_valid", {7'd0, valid}, 8'd0);
        check("rst_sel",   {6'd0, sel},   8'd0);
        check("rst_pend",  {4'd0, pend},  8'd0);

        // Reset mid-operation
        drive(1'b1, 4'b1111, 1'b0);
        step();
        drive(1'b0, 4'b0000, 1'b0);
        check("mid_valid_pre", {7'd0, valid}, 8'd1);
        check("mid_pend_pre",  {4'd0, pend},  8'h0f);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_valid", {7'd0, valid}, 8'd0);
        check("mid_sel",   {6'd0, sel},   8'd0);
        check("mid_pend",  {4'd0, pend},  8'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        check("mid_after_valid", {7'd0, valid}, 8'd0);

        // Single request
        do_reset();
        drive(1'b1, 4'b0100, 1'b1);
        step();
        drive(1'b1, 4'b0000, 1'b1);
        check("single_valid1", {7'd0, valid}, 8'd1);
        check("single_sel1",   {6'd0, sel},   8'd2);
        check("single_pend1",  {4'd0, pend},  8'h04);
        step();
        check("single_valid2", {7'd0, valid}, 8'd0);
        check("single_pend2",  {4'd0, pend},  8'd0);

        // Enable gating
        do_reset();
        drive(1'b0, 4'b1111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("gate_pend",  {4'd0, pend},  8'd0);
            check("gate_valid", {7'd0, valid}, 8'd0);
        end

        // Round-robin burst and wrap
        do_reset();
        drive(1'b1, 4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 4'b0000, 1'b1);
            check("burst_valid", {7'd0, valid}, 8'd1);
            check("burst_sel",   {6'd0, sel},   {6'd0, burst_exp[i]});
        end
        step();
        check("burst_end_valid", {7'd0, valid}, 8'd0);
        check("burst_end_pend",  {4'd0, pend},  8'd0);
        // Pointer wrapped to 00: the next pair of requests starts at index 0.
        drive(1'b1, 4'b1001, 1'b0);
        step();
        drive(1'b1, 4'b0000, 1'b0);
        check("burst_ptr_wrap", {6'd0, sel}, 8'd0);

        // Stall and pointer wrap
        do_reset();
        drive(1'b1, 4'b0010, 1'b0);
        step();
        check("stall_valid", {7'd0, valid}, 8'd1);
        check("stall_sel",   {6'd0, sel},   8'd1);
        drive(1'b1, 4'b0001, 1'b0);
        step();
        check("stall_hold_sel", {6'd0, sel},  8'd1);
        check("stall_pend",     {4'd0, pend}, 8'h03);
        drive(1'b1, 4'b0000, 1'b1);
        step();
        check("stall_wrap_sel",   {6'd0, sel},   8'd0);
        check("stall_wrap_valid", {7'd0, valid}, 8'd1);

        // Set-wins collision
        do_reset();
        drive(1'b1, 4'b0010, 1'b0);
        step();
        drive(1'b1, 4'b0010, 1'b1);
        step();
        drive(1'b1, 4'b0000, 1'b1);
        check("coll_pend",  {4'd0, pend},  8'h02);
        check("coll_sel",   {6'd0, sel},   8'd1);
        check("coll_valid", {7'd0, valid}, 8'd1);
        step();
        check("coll_drain", {7'd0, valid}, 8'd0);

        // Fixed priority vs round-robin on a re-requested low index
        do_reset();
        drive(1'b1, 4'b1010, 1'b1);
        step();
        drive(1'b1, 4'b0000, 1'b1);
        check("fp_sel1", {6'd0, sel_fp}, 8'd1);
        step();
        check("fp_sel2",   {6'd0, sel_fp},   8'd3);
        check("fp_valid2", {7'd0, valid_fp}, 8'd1);
        step();
        check("fp_end", {7'd0, valid_fp}, 8'd0);

        do_reset();
        drive(1'b1, 4'b1010, 1'b1);
        step();
        drive(1'b1, 4'b0010, 1'b1);
        step();
        drive(1'b1, 4'b0000, 1'b1);
        check("rr_skip_sel", {6'd0, sel},    8'd3);
        check("fp_repeat",   {6'd0, sel_fp}, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
